// File: rtl/csa_pipe_adder.sv
// Two-stage carry-select adder/subtractor with valid/ready handshake.
// Stage 1 computes the low-half sum plus both high-half candidates; stage 2
// picks the high half using the registered low carry. WIDTH must be even and >= 4.
module csa_pipe_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned HW = WIDTH / 2;

    // stage 1 registers
    logic          s1_valid_q, s1_valid_d;
    logic [HW-1:0] s1_lsum_q,  s1_lsum_d;
    logic          s1_lc_q,    s1_lc_d;
    logic [HW-1:0] s1_h0_q,    s1_h0_d;
    logic [HW-1:0] s1_h1_q,    s1_h1_d;
    logic          s1_hc0_q,   s1_hc0_d;
    logic          s1_hc1_q,   s1_hc1_d;
    logic          s1_ov0_q,   s1_ov0_d;
    logic          s1_ov1_q,   s1_ov1_d;

    // stage 2 registers (drive the outputs directly)
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] dout_q,     dout_d;
    logic             co_q,       co_d;
    logic             ov_q,       ov_d;
    logic             zero_q,     zero_d;

    // handshake / stage-1 arithmetic
    logic             adv1_c, adv2_c, accept_c;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [HW:0]      lo_sum, hi_sum0, hi_sum1;

    // Stall chain: a stage advances when its successor is empty or advancing.
    always_comb begin
        adv2_c   = !s2_valid_q || out_ready;
        adv1_c   = !s1_valid_q || adv2_c;
        in_ready = adv1_c && !rst;
        accept_c = in_valid && in_ready;
    end

    // Effective operands and the half-width partial sums.
    always_comb begin
        b_eff   = sub ? ~din2 : din2;
        cin_eff = sub | carry_in;
        lo_sum  = {1'b0, din1[HW-1:0]} + {1'b0, b_eff[HW-1:0]} + (HW+1)'(cin_eff);
        hi_sum0 = {1'b0, din1[WIDTH-1:HW]} + {1'b0, b_eff[WIDTH-1:HW]};
        hi_sum1 = hi_sum0 + (HW+1)'(1);
    end

    // Stage 1 next state: capture on accept, otherwise hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lsum_d  = s1_lsum_q;
        s1_lc_d    = s1_lc_q;
        s1_h0_d    = s1_h0_q;
        s1_h1_d    = s1_h1_q;
        s1_hc0_d   = s1_hc0_q;
        s1_hc1_d   = s1_hc1_q;
        s1_ov0_d   = s1_ov0_q;
        s1_ov1_d   = s1_ov1_q;
        if (adv1_c) begin
            s1_valid_d = accept_c;
        end
        if (accept_c) begin
            s1_lsum_d = lo_sum[HW-1:0];
            s1_lc_d   = lo_sum[HW];
            s1_h0_d   = hi_sum0[HW-1:0];
            s1_h1_d   = hi_sum1[HW-1:0];
            s1_hc0_d  = hi_sum0[HW];
            s1_hc1_d  = hi_sum1[HW];
            // carry into the MSB recovered from the sum bit and the operand bits
            s1_ov0_d  = (hi_sum0[HW-1] ^ din1[WIDTH-1] ^ b_eff[WIDTH-1]) ^ hi_sum0[HW];
            s1_ov1_d  = (hi_sum1[HW-1] ^ din1[WIDTH-1] ^ b_eff[WIDTH-1]) ^ hi_sum1[HW];
        end
    end

    // Stage 2 next state: select the high candidate by the low carry.
    always_comb begin
        s2_valid_d = s2_valid_q;
        dout_d     = dout_q;
        co_d       = co_q;
        ov_d       = ov_q;
        zero_d     = zero_q;
        if (adv2_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dout_d = s1_lc_q ? {s1_h1_q, s1_lsum_q} : {s1_h0_q, s1_lsum_q};
                co_d   = s1_lc_q ? s1_hc1_q : s1_hc0_q;
                ov_d   = s1_lc_q ? s1_ov1_q : s1_ov0_q;
                zero_d = (dout_d == '0);
            end
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_lsum_q  <= '0;
            s1_lc_q    <= 1'b0;
            s1_h0_q    <= '0;
            s1_h1_q    <= '0;
            s1_hc0_q   <= 1'b0;
            s1_hc1_q   <= 1'b0;
            s1_ov0_q   <= 1'b0;
            s1_ov1_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            dout_q     <= '0;
            co_q       <= 1'b0;
            ov_q       <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lsum_q  <= s1_lsum_d;
            s1_lc_q    <= s1_lc_d;
            s1_h0_q    <= s1_h0_d;
            s1_h1_q    <= s1_h1_d;
            s1_hc0_q   <= s1_hc0_d;
            s1_hc1_q   <= s1_hc1_d;
            s1_ov0_q   <= s1_ov0_d;
            s1_ov1_q   <= s1_ov1_d;
            s2_valid_q <= s2_valid_d;
            dout_q     <= dout_d;
            co_q       <= co_d;
            ov_q       <= ov_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign dout      = dout_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder (WIDTH=16): arithmetic model with a
// result queue, per-cycle checker on the falling edge, directed stimulus.
module tb_csa_pipe_adder;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dout;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    csa_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din1      (din1),
        .din2      (din2),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         co;
        logic         ov;
        logic         z;
        int           acc;
        bit           pin;
        bit           seen;
        logic [W-1:0] pd;
        logic         pco;
        logic         pov;
        logic         pz;
    } exp_t;

    exp_t q[$];
    exp_t e_new;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   prev_rst = 1'b0;
    bit   end_check = 1'b0;
    bit   end_done  = 1'b0;

    // literal expectations attached to the beat being offered
    bit           pin_en;
    logic [W-1:0] pin_d;
    logic         pin_co, pin_ov, pin_z;

    // directed stream vectors
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vc [8];
    logic         vs [8];

    // Result of A+B+cin or A-B from plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic s);
        exp_t e;
        int   sr;
        int   ur;
        if (s) begin
            sr   = int'($signed(a)) - int'($signed(b));
            ur   = int'(a) - int'(b);
            e.co = (a >= b);
        end else begin
            sr   = int'($signed(a)) + int'($signed(b)) + int'(cin);
            ur   = int'(a) + int'(b) + int'(cin);
            e.co = (ur > 65535);
        end
        e.d    = W'(ur);
        e.ov   = (sr > 32767) || (sr < -32768);
        e.z    = (e.d == '0);
        e.acc  = 0;
        e.pin  = 1'b0;
        e.seen = 1'b0;
        e.pd   = '0;
        e.pco  = 1'b0;
        e.pov  = 1'b0;
        e.pz   = 1'b0;
        return e;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Checker: every falling edge, compare handshake and outputs with the model.
    always @(negedge clk) begin
        cyc++;
        if (end_check && !end_done) begin
            chk("drain_empty", 32'(q.size()), 32'd0);
            end_done = 1'b1;
        end
        if (prev_rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_dout",      32'(dout),      32'd0);
            chk("rst_carry_out", 32'(carry_out), 32'd0);
            chk("rst_overflow",  32'(overflow),  32'd0);
            chk("rst_zero",      32'(zero),      32'd0);
        end
        if (rst) begin
            chk("in_ready_rst", 32'(in_ready), 32'd0);
            q.delete();
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got dout %0h, want no beat (cycle %0d)", dout, cyc);
                end else begin
                    chk("dout",      32'(dout),      32'(q[0].d));
                    chk("carry_out", 32'(carry_out), 32'(q[0].co));
                    chk("overflow",  32'(overflow),  32'(q[0].ov));
                    chk("zero",      32'(zero),      32'(q[0].z));
                    if (q[0].pin && !q[0].seen) begin
                        chk("latency",       32'(cyc - q[0].acc), 32'd2);
                        chk("pin_dout",      32'(dout),      32'(q[0].pd));
                        chk("pin_carry_out", 32'(carry_out), 32'(q[0].pco));
                        chk("pin_overflow",  32'(overflow),  32'(q[0].pov));
                        chk("pin_zero",      32'(zero),      32'(q[0].pz));
                    end
                    q[0].seen = 1'b1;
                    if (out_ready) begin
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                e_new     = model(din1, din2, carry_in, sub);
                e_new.acc = cyc;
                e_new.pin = pin_en;
                e_new.pd  = pin_d;
                e_new.pco = pin_co;
                e_new.pov = pin_ov;
                e_new.pz  = pin_z;
                q.push_back(e_new);
            end
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat with literal expectations, then idle until it drains.
    task automatic send_pinned(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic s,
                               input logic [W-1:0] pd, input logic pco,
                               input logic pov, input logic pz);
        tick();
        in_valid = 1'b1;
        din1     = a;
        din2     = b;
        carry_in = cin;
        sub      = s;
        pin_en   = 1'b1;
        pin_d    = pd;
        pin_co   = pco;
        pin_ov   = pov;
        pin_z    = pz;
        tick();
        in_valid = 1'b0;
        pin_en   = 1'b0;
        carry_in = ~cin;
        sub      = ~s;
        repeat (3) tick();
    endtask

    // Stream n vectors as fast as accepted; out_ready low for cycles lo..hi.
    task automatic run_stream(input int n, input int lo, input int hi);
        int idx;
        idx = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            out_ready = !(c >= lo && c <= hi);
            if (idx < n) begin
                in_valid = 1'b1;
                din1     = va[idx];
                din2     = vb[idx];
                carry_in = vc[idx];
                sub      = vs[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (idx == n && c > hi) break;
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        din1      = '0;
        din2      = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        pin_en    = 1'b0;
        pin_d     = '0;
        pin_co    = 1'b0;
        pin_ov    = 1'b0;
        pin_z     = 1'b0;

        va[0] = 16'h1111; vb[0] = 16'h2222; vc[0] = 1'b0; vs[0] = 1'b0;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 1'b1; vs[1] = 1'b0;
        va[2] = 16'h0000; vb[2] = 16'h0001; vc[2] = 1'b1; vs[2] = 1'b1;
        va[3] = 16'h7FFF; vb[3] = 16'hFFFF; vc[3] = 1'b0; vs[3] = 1'b1;
        va[4] = 16'h00FF; vb[4] = 16'hFF01; vc[4] = 1'b0; vs[4] = 1'b0;
        va[5] = 16'hABCD; vb[5] = 16'h5432; vc[5] = 1'b1; vs[5] = 1'b0;
        va[6] = 16'h8000; vb[6] = 16'hFFFF; vc[6] = 1'b0; vs[6] = 1'b0;
        va[7] = 16'h0100; vb[7] = 16'h0100; vc[7] = 1'b0; vs[7] = 1'b1;

        tick();
        tick();
        rst = 1'b0;

        // isolated beats with hand-computed results
        send_pinned(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send_pinned(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send_pinned(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        send_pinned(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        send_pinned(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send_pinned(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send_pinned(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        send_pinned(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        send_pinned(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // back-to-back stream, then the same vectors with a consumer stall
        run_stream(8, 100, 0);
        repeat (3) tick();
        run_stream(6, 3, 7);
        repeat (3) tick();

        // two beats in flight, consumer stalled, then a one-cycle reset
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din1 = 16'h0003; din2 = 16'h0004; carry_in = 1'b0; sub = 1'b0;
        tick();
        din1 = 16'h0010; din2 = 16'h0001; carry_in = 1'b0; sub = 1'b1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din1 = 16'h4000; din2 = 16'h4000; carry_in = 1'b0; sub = 1'b0;
        pin_en = 1'b1; pin_d = 16'h8000; pin_co = 1'b0; pin_ov = 1'b1; pin_z = 1'b0;
        tick();
        in_valid = 1'b0;
        pin_en   = 1'b0;

        repeat (10) tick();
        end_check = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_pipe_adder.md
CSA_PIPE_ADDER -- requirements
Module: csa_pipe_adder

Interface
REQ-001 The block SHALL run on one clock and use a synchronous, active-high reset: clk (rising edge) and rst (synchronous, active-high).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the operand and result width; it must be even and at least 4.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 din1  input  WIDTH  operand A.
REQ-008 din2  input  WIDTH  operand B.
REQ-009 carry_in  input  1  carry into the LSB; used in add mode only.
REQ-010 sub  input  1  0 = A+B+carry_in; 1 = A-B.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 dout  output  WIDTH  sum or difference.
REQ-014 carry_out  output  1  raw carry out of the MSB.
REQ-015 overflow  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  dout == 0.

Function
REQ-017 Split the operands into low half L (bits WIDTH/2-1:0) and high half H.
REQ-018 Effective operand B' SHALL be din2 when sub=0 and ~din2 when sub=1.
REQ-019 Effective carry SHALL be carry_in when sub=0 and 1 when sub=1 (carry_in ignored).
REQ-020 Stage 1, on accept, SHALL register:
  - L sum and L carry of A+B'+cin;
  - H candidate sums, carries and overflows for carry-in 0 and for carry-in 1.
REQ-021 Stage 2 SHALL select the H candidate using the registered L carry, then register dout, carry_out, overflow and zero.
REQ-022 Overflow SHALL be (carry into MSB) XOR (carry out of MSB) for the selected candidate.
REQ-023 Latency SHALL be exactly 2 cycles from accept to out_valid with no backpressure.
REQ-024 Throughput SHALL be one beat per cycle.
REQ-025 Handshake and stall logic:
  - accept = in_valid && in_ready; output transfer = out_valid && out_ready;
  - adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational);
  - a stage whose adv is 0 SHALL hold all registered data and its valid bit unchanged.
REQ-026 Results SHALL emerge in acceptance order with no loss or duplication.
REQ-027 In-flight results SHALL be independent of subsequent changes to sub or carry_in.
REQ-028 Simultaneous accept and output transfer while full SHALL be legal and keep the pipeline full.
REQ-029 dout, carry_out, overflow and zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 When out_valid=0 the data outputs SHALL hold their last values; their contents are don't-care.

Reset
REQ-031 While rst=1 at a rising edge, s1_valid and s2_valid SHALL clear to 0.
REQ-032 Reset values: out_valid=0, dout=0, carry_out=0, overflow=0, zero=0.
REQ-033 in_ready SHALL be 0 during the reset cycle.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight beats; no partial result is delivered.
REQ-035 The first accept SHALL be possible in the cycle after rst deasserts.

Verification (WIDTH=16)
REQ-036 Signed overflow: add 0x7FFF + 0x0001, cin=0 -> dout=0x8000, carry_out=0, overflow=1, zero=0, out_valid 2 cycles after accept.
REQ-037 Unsigned wrap: add 0xFFFF + 0x0001, cin=0 -> dout=0x0000, carry_out=1, overflow=0, zero=1.
REQ-038 Carry-select boundary:
  - add 0x00FF + 0x0001, cin=0 -> dout=0x0100, carry_out=0;
  - add 0x00FF + 0x0000, cin=1 -> dout=0x0100.
REQ-039 Subtract:
  - 0x0005 - 0x0007, carry_in=1 -> dout=0xFFFE, carry_out=0, overflow=0;
  - 0x8000 - 0x0001 -> dout=0x7FFF, carry_out=1, overflow=1.
REQ-040 Backpressure: stream 6 beats with out_ready held low for cycles 3-7.
  - in_ready SHALL drop once both stages hold data.
  - All 6 results SHALL arrive in order, each held stable while stalled.
  - Full throughput SHALL resume once out_ready=1.
REQ-041 Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, neither beat is ever output, and a new beat accepted afterwards appears 2 cycles later.
